// File: rtl/maze_mem_arbiter.sv
// Round-robin arbiter/sequencer for two requesters sharing the single-port maze bit memory.
// Define MAZE_ARB_STATS_EN to add the saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module maze_mem_arbiter #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               r0_req,
  input  logic               r0_wr,
  input  logic [COORD_W-1:0] r0_x,
  input  logic [COORD_W-1:0] r0_y,
  input  logic               r0_din,
  output logic               r0_ack,
  output logic               r0_dout,
  input  logic               r1_req,
  input  logic               r1_wr,
  input  logic [COORD_W-1:0] r1_x,
  input  logic [COORD_W-1:0] r1_y,
  input  logic               r1_din,
  output logic               r1_ack,
  output logic               r1_dout,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  output logic               mem_din,
  output logic               mem_rd,
  output logic               mem_wr,
  input  logic               mem_dout,
  output logic               busy
`ifdef MAZE_ARB_STATS_EN
  ,
  output logic [15:0]        gnt_cnt0,
  output logic [15:0]        gnt_cnt1
`endif
);

  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  logic               r_ptr;
  logic               r_gnt;
  logic               r_wr;
  logic               r_busy;
  logic               r_ack0;
  logic               r_ack1;
  logic               r_rdata;
  logic               r_mem_din;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic [COORD_W-1:0] r_mem_x;
  logic [COORD_W-1:0] r_mem_y;
  logic [CNT_W-1:0]   r_cnt;

  logic               w_any;
  logic               w_gnt;
  logic               w_wr;
  logic               w_din;
  logic [COORD_W-1:0] w_x;
  logic [COORD_W-1:0] w_y;

  // Winner: a lone requester wins outright, a tie goes to the pointer.
  assign w_any = r0_req | r1_req;
  assign w_gnt = (r0_req & r1_req) ? r_ptr : r1_req;
  assign w_wr  = w_gnt ? r1_wr  : r0_wr;
  assign w_din = w_gnt ? r1_din : r0_din;
  assign w_x   = w_gnt ? r1_x   : r0_x;
  assign w_y   = w_gnt ? r1_y   : r0_y;

  // Sequencer: the memory strobes are loaded on the grant edge so they appear during ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 1'b0;
      r_gnt     <= 1'b0;
      r_wr      <= 1'b0;
      r_busy    <= 1'b0;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_rdata   <= 1'b0;
      r_mem_din <= 1'b0;
      r_mem_rd  <= 1'b0;
      r_mem_wr  <= 1'b0;
      r_mem_x   <= '0;
      r_mem_y   <= '0;
      r_cnt     <= '0;
    end else begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_gnt     <= w_gnt;
            r_ptr     <= ~w_gnt;
            r_wr      <= w_wr;
            r_mem_x   <= w_x;
            r_mem_y   <= w_y;
            r_mem_din <= w_din;
            r_mem_wr  <= w_wr;
            r_mem_rd  <= ~w_wr;
            r_busy    <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_wr) begin
            r_rdata <= 1'b0;
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= CNT_W'(RD_LAT);
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_rdata <= mem_dout;
            r_ack0  <= ~r_gnt;
            r_ack1  <= r_gnt;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign r0_ack  = r_ack0;
  assign r1_ack  = r_ack1;
  assign r0_dout = r_ack0 & r_rdata;
  assign r1_dout = r_ack1 & r_rdata;
  assign mem_x   = r_mem_x;
  assign mem_y   = r_mem_y;
  assign mem_din = r_mem_din;
  assign mem_rd  = r_mem_rd;
  assign mem_wr  = r_mem_wr;
  assign busy    = r_busy;

`ifdef MAZE_ARB_STATS_EN
  logic [15:0] r_gnt_cnt0;
  logic [15:0] r_gnt_cnt1;

  // Completed-access counters, bumped on the DONE cycle and held at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt_cnt0 <= '0;
      r_gnt_cnt1 <= '0;
    end else if (r_state == S_DONE) begin
      if (!r_gnt && (r_gnt_cnt0 != 16'hFFFF)) r_gnt_cnt0 <= r_gnt_cnt0 + 16'd1;
      if (r_gnt && (r_gnt_cnt1 != 16'hFFFF))  r_gnt_cnt1 <= r_gnt_cnt1 + 16'd1;
    end
  end

  assign gnt_cnt0 = r_gnt_cnt0;
  assign gnt_cnt1 = r_gnt_cnt1;
`endif

endmodule
